// File: rtl/page_menu_pkg.sv
// Shared types and constants for the menu page: key codes, screen/output
// structs, top-level state codes, menu labels and their target states.
// Optional feature macro used by the files that import this package:
// MENU_AUTO_REPEAT_EN (hold-to-repeat for UP/DOWN).

`ifndef UP
`define UP    4'b0001
`endif
`ifndef DOWN
`define DOWN  4'b0010
`endif
`ifndef LEFT
`define LEFT  4'b0100
`endif
`ifndef RIGHT
`define RIGHT 4'b1000
`endif

package page_menu_pkg;

   localparam logic [3:0] KEY_UP    = `UP;
   localparam logic [3:0] KEY_DOWN  = `DOWN;
   localparam logic [3:0] KEY_LEFT  = `LEFT;
   localparam logic [3:0] KEY_RIGHT = `RIGHT;

   localparam int N_ROWS      = 20;
   localparam int ROW_CHARS   = 32;
   localparam int LABEL_CHARS = 30;

   typedef logic [N_ROWS-1:0][8*ROW_CHARS-1:0] ScreenText;

   typedef enum logic [2:0] {
      INIT, MENU, GAME, SCORES, SETTINGS, CREDITS, HELP, SOUND
   } TopState;

   typedef enum logic [1:0] {ARM, IDLE, HELD, REPEAT} MenuFsm;

   // Page-input slice of the shared user input bus.
   typedef struct packed {
      logic [3:0] arrow_keys;
   } UserInput;

   typedef struct packed {
      ScreenText   text;
      TopState     state;
      logic [63:0] seg;
   } ProgramOutput;

   // Left-justify a short label literal and pad it with spaces to 30 chars.
   function automatic logic [8*LABEL_CHARS-1:0] pad_label(input logic [8*LABEL_CHARS-1:0] s);
      logic [8*LABEL_CHARS-1:0] r;
      r = s;
      for (int i = 0; i < LABEL_CHARS; i++) begin
         if (r[8*LABEL_CHARS-1 -: 8] == 8'h00) r = {r[8*LABEL_CHARS-9:0], 8'h20};
      end
      return r;
   endfunction

   localparam logic [8*LABEL_CHARS-1:0] MENU_LABEL [8] = '{
      pad_label("START GAME"),
      pad_label("HIGH SCORES"),
      pad_label("SETTINGS"),
      pad_label("CREDITS"),
      pad_label("HELP"),
      pad_label("TWO PLAYER"),
      pad_label("SOUND TEST"),
      pad_label("QUIT")
   };

   localparam TopState MENU_TARGET [8] = '{
      GAME, SCORES, SETTINGS, CREDITS, HELP, GAME, SOUND, INIT
   };

   localparam logic [8*ROW_CHARS-1:0] BLANK_ROW = {ROW_CHARS{8'h20}};
   localparam logic [8*ROW_CHARS-1:0] TITLE_ROW = {{13{8'h20}}, "MENU", {15{8'h20}}};

   // A valid key is exactly one arrow; chords and zero are NONE.
   function automatic logic is_key(input logic [3:0] k);
      return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
   endfunction

   function automatic logic is_updown(input logic [3:0] k);
      return (k == KEY_UP) || (k == KEY_DOWN);
   endfunction

endpackage

// File: rtl/page_menu_key_repeat.sv
// key_repeat: arrow-key decode, press FSM (ARM/IDLE/HELD/REPEAT) and the
// hold counter. Emits a one-cycle action strobe plus the key it applies to.
// With MENU_AUTO_REPEAT_EN defined, a held UP/DOWN repeats after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles; without it the
// REPEAT state and counter are not built and each press acts once.

module key_repeat
   import page_menu_pkg::*;
`ifdef MENU_AUTO_REPEAT_EN
#(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 15_000_000
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       active,
   input  logic [3:0] arrow_keys,
   output logic       fire,
   output logic [3:0] key
);

   MenuFsm     fsm_q, fsm_d;
   logic [3:0] held_q, held_d;
   logic       key_valid;
   logic       same_key;

   assign key_valid = is_key(arrow_keys);
   assign same_key  = (arrow_keys == held_q);

`ifdef MENU_AUTO_REPEAT_EN
   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             delay_done, period_done;

   // Saturate so a LEFT/RIGHT held forever never wraps into a false repeat.
   assign cnt_inc     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
   assign delay_done  = is_updown(held_q) && (cnt_q == CNT_W'(REPEAT_DELAY - 1));
   assign period_done = (cnt_q == CNT_W'(REPEAT_PERIOD - 1));
`endif

   // State, held key and hold counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= ARM;
         held_q <= '0;
`ifdef MENU_AUTO_REPEAT_EN
         cnt_q  <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         fsm_q  <= fsm_d;
         held_q <= held_d;
`ifdef MENU_AUTO_REPEAT_EN
         cnt_q  <= cnt_d;
`endif
      end
   end

   // Next-state logic; leaving the page forces ARM so a carried-over key is ignored.
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      fsm_d  = fsm_q;
      held_d = held_q;
`ifdef MENU_AUTO_REPEAT_EN
      cnt_d  = '0;
`endif
      if (!active) begin
         fsm_d = ARM;
      end else begin
         case (fsm_q)
            ARM: begin
               if (!key_valid) fsm_d = IDLE;
            end
            IDLE: begin
               if (key_valid) begin
                  fsm_d  = HELD;
                  held_d = arrow_keys;
               end
            end
            HELD: begin
               if (!same_key) begin
                  fsm_d = IDLE;
               end
`ifdef MENU_AUTO_REPEAT_EN
               else if (delay_done) begin
                  fsm_d = REPEAT;
               end else begin
                  cnt_d = cnt_inc;
               end
`endif
            end
`ifdef MENU_AUTO_REPEAT_EN
            REPEAT: begin
               if (!same_key) begin
                  fsm_d = IDLE;
               end else if (!period_done) begin
                  cnt_d = cnt_inc;
               end
            end
`endif
            default: fsm_d = ARM;
         endcase
      end
   end

   // Action strobe: first press from IDLE, then the timed repeats of a held UP/DOWN.
   always_comb begin
      fire = 1'b0;
      key  = held_q;
      if (active) begin
         case (fsm_q)
            IDLE: begin
               fire = key_valid;
               key  = arrow_keys;
            end
`ifdef MENU_AUTO_REPEAT_EN
            HELD:    fire = same_key && delay_done;
            REPEAT:  fire = same_key && period_done;
`endif
            default: fire = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/page_menu.sv
// page_menu: parametrised menu page. Holds the cursor and requested top
// state, and renders the registered screen text and 7-seg string.
// Optional hold-to-repeat for UP/DOWN when MENU_AUTO_REPEAT_EN is defined;
// REPEAT_DELAY/REPEAT_PERIOD exist only in that build.

module page_menu
   import page_menu_pkg::*;
#(
   parameter int N_ITEMS    = 4,
   parameter int FIRST_ROW  = 10,
   parameter int ROW_STRIDE = 2
`ifdef MENU_AUTO_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 15_000_000
`endif
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         active,
   input  UserInput     user_in,
   output ProgramOutput menu_out
);

   localparam int         ROW_W     = $clog2(N_ROWS);
   localparam logic [2:0] LAST_ITEM = 3'(N_ITEMS - 1);
   localparam logic [15:0] MARK_ON  = "> ";
   localparam logic [15:0] MARK_OFF = "  ";

   logic        fire;
   logic [3:0]  key;
   logic [2:0]  cursor_q;
   TopState     state_q;
   logic        active_q;
   ScreenText   text_q;
   logic [63:0] seg_q;

   key_repeat
`ifdef MENU_AUTO_REPEAT_EN
   #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   )
`endif
   u_key_repeat (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (active),
      .arrow_keys (user_in.arrow_keys),
      .fire       (fire),
      .key        (key)
   );

   function automatic ScreenText render_text(input logic [2:0] cur);
      ScreenText t;
      for (int r = 0; r < N_ROWS; r++) t[ROW_W'(r)] = BLANK_ROW;
      t[ROW_W'(2)] = TITLE_ROW;
      for (int i = 0; i < N_ITEMS; i++) begin
         t[ROW_W'(FIRST_ROW + i*ROW_STRIDE)] = {(cur == 3'(i)) ? MARK_ON : MARK_OFF, MENU_LABEL[3'(i)]};
      end
      return t;
   endfunction

   function automatic logic [63:0] render_seg(input logic [2:0] cur);
      return {"menu  ", 8'h30, 8'h31 + {5'b0, cur}};
   endfunction

   // Cursor moves with wrap on UP/DOWN actions; a single entry never moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cursor_q <= '0;
      end else if (fire) begin
         if (key == KEY_UP) begin
            cursor_q <= (cursor_q == 3'd0) ? LAST_ITEM : cursor_q - 3'd1;
         end else if (key == KEY_DOWN) begin
            cursor_q <= (cursor_q == LAST_ITEM) ? 3'd0 : cursor_q + 3'd1;
         end
      end
   end

   // Requested top state: reload MENU on page entry, else RIGHT/LEFT actions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         state_q  <= MENU;
      end else begin
         active_q <= active;
         if (active && !active_q) begin
            state_q <= MENU;
         end else if (fire && (key == KEY_RIGHT)) begin
            state_q <= MENU_TARGET[cursor_q];
         end else if (fire && (key == KEY_LEFT)) begin
            state_q <= INIT;
         end
      end
   end

   // Screen and 7-seg render, one cycle behind the cursor register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_q <= render_text(3'd0);
         seg_q  <= render_seg(3'd0);
      end else begin
         text_q <= render_text(cursor_q);
         seg_q  <= render_seg(cursor_q);
      end
   end

   assign menu_out = '{text: text_q, state: state_q, seg: seg_q};

endmodule

// File: tb/tb_page_menu.sv
// Self-checking bench for page_menu: a press/hold model derived from the
// key rules drives expected state/seg/text, compared on every falling edge,
// plus directed scenarios with literal expectations and a random phase.
// Honors MENU_AUTO_REPEAT_EN for the repeat expectations.

module tb_page_menu;
   import page_menu_pkg::*;

   localparam int N  = 4;
   localparam int FR = 10;
   localparam int RS = 2;
   localparam int D  = 10;
   localparam int P  = 4;
`ifdef MENU_AUTO_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         active;
   logic [3:0]   arrow;
   UserInput     user_in;
   ProgramOutput menu_out;

   assign user_in = '{arrow_keys: arrow};

   always #5 clk = ~clk;

   page_menu #(
      .N_ITEMS       (N),
      .FIRST_ROW     (FR),
      .ROW_STRIDE    (RS)
`ifdef MENU_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY  (D),
      .REPEAT_PERIOD (P)
`endif
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (active),
      .user_in  (user_in),
      .menu_out (menu_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic check_text(input ScreenText want);
      int bad_row;
      n_cmp++;
      if (menu_out.text !== want) begin
         n_bad++;
         bad_row = 0;
         for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (menu_out.text[r] !== want[r]) bad_row = r;
         end
         $display("FAIL text row %0d: got %h want %h", bad_row, menu_out.text[bad_row], want[bad_row]);
      end
   endtask

   function automatic ScreenText exp_text(input int c);
      ScreenText t;
      for (int r = 0; r < N_ROWS; r++) t[r] = {32{8'h20}};
      t[2] = {{13{8'h20}}, "MENU", {15{8'h20}}};
      for (int i = 0; i < N; i++) begin
         t[FR + i*RS] = {(i == c) ? 16'h3E20 : 16'h2020, MENU_LABEL[i]};
      end
      return t;
   endfunction

   function automatic logic [63:0] exp_seg(input int c);
      return {"menu  ", 8'(48 + (c + 1) / 10), 8'(48 + (c + 1) % 10)};
   endfunction

   function automatic bit valid_key(input logic [3:0] k);
      return k == KEY_UP || k == KEY_DOWN || k == KEY_LEFT || k == KEY_RIGHT;
   endfunction

   // ---------------- behavioural model ----------------
   int         cyc = 0;
   int         m_cursor;
   int         prev_cursor;
   TopState    m_state;
   bit         m_act_prev;
   bit         need_release;
   logic [3:0] held;
   int         age;
   int         act_log[$];

   always @(posedge clk) begin
      bit         act;
      logic [3:0] k;
      cyc++;
      prev_cursor = m_cursor;
      if (!rst_n) begin
         m_cursor     = 0;
         prev_cursor  = 0;
         m_state      = MENU;
         m_act_prev   = 1'b0;
         need_release = 1'b1;
         held         = 4'd0;
         age          = 0;
      end else begin
         act = 1'b0;
         k   = held;
         if (!active) begin
            need_release = 1'b1;
            held         = 4'd0;
         end else begin
            if (!m_act_prev) m_state = MENU;
            if (need_release) begin
               if (!valid_key(arrow)) need_release = 1'b0;
            end else if (held != 4'd0) begin
               if (arrow != held) begin
                  held = 4'd0;
               end else begin
                  age++;
                  if (RPT_EN && (held == KEY_UP || held == KEY_DOWN) &&
                      (age == D || (age > D && (age - D) % P == 0))) act = 1'b1;
               end
            end else if (valid_key(arrow)) begin
               held = arrow;
               k    = arrow;
               age  = 0;
               act  = 1'b1;
            end
            if (act) begin
               act_log.push_back(cyc);
               if (k == KEY_UP)    m_cursor = (m_cursor + N - 1) % N;
               if (k == KEY_DOWN)  m_cursor = (m_cursor + 1) % N;
               if (k == KEY_RIGHT) m_state  = MENU_TARGET[m_cursor];
               if (k == KEY_LEFT)  m_state  = INIT;
            end
         end
         m_act_prev = active;
      end
   end

   // ---------------- per-cycle compare ----------------
   int          seg_changes = 0;
   logic [63:0] last_seg    = '0;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("state", 256'(menu_out.state), 256'(m_state));
         check("seg", 256'(menu_out.seg), 256'(exp_seg(prev_cursor)));
         check_text(exp_text(prev_cursor));
         if (menu_out.seg !== last_seg) seg_changes++;
         last_seg = menu_out.seg;
      end
   end

   task automatic drive(input logic [3:0] k, input logic a, input int n);
      for (int j = 0; j < n; j++) begin
         arrow  = k;
         active = a;
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0;
      int exp_off[5];
      logic [3:0] rk;
      exp_off = '{0, 10, 14, 18, 22};

      rst_n  = 1'b0;
      active = 1'b0;
      arrow  = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset picture
      check("reset seg", 256'(menu_out.seg), 256'("menu  01"));
      check("reset state", 256'(menu_out.state), 256'(MENU));
      check("reset row10", 256'(menu_out.text[10]), {"> ", "START GAME", {20{8'h20}}});
      check("reset title", 256'(menu_out.text[2]), {{13{8'h20}}, "MENU", {15{8'h20}}});

      // 1: three DOWN taps
      drive(4'd0, 1'b1, 2);
      for (int i = 0; i < 3; i++) begin
         drive(KEY_DOWN, 1'b1, 1);
         drive(4'd0, 1'b1, 1);
      end
      drive(4'd0, 1'b1, 2);
      check("t1 seg", 256'(menu_out.seg), 256'("menu  04"));
      check("t1 marker row16", 256'(menu_out.text[16][255:240]), 256'("> "));
      check("t1 row10 unmarked", 256'(menu_out.text[10][255:240]), 256'("  "));
      check("t1 model cursor", 256'(m_cursor), 256'(3));

      // 2: wrap both ways
      drive(KEY_DOWN, 1'b1, 1);
      drive(4'd0, 1'b1, 2);
      check("t2 wrap down", 256'(menu_out.seg), 256'("menu  01"));
      drive(KEY_UP, 1'b1, 1);
      drive(4'd0, 1'b1, 2);
      check("t2 wrap up", 256'(menu_out.seg), 256'("menu  04"));

      // 3: RIGHT/LEFT and page re-entry
      drive(KEY_UP, 1'b1, 1);
      drive(4'd0, 1'b1, 1);
      drive(KEY_RIGHT, 1'b1, 1);
      check("t3 right", 256'(menu_out.state), 256'(SETTINGS));
      drive(4'd0, 1'b1, 1);
      drive(4'd0, 1'b0, 2);
      check("t3 persist", 256'(menu_out.state), 256'(SETTINGS));
      drive(4'd0, 1'b1, 1);
      check("t3 reload", 256'(menu_out.state), 256'(MENU));
      drive(KEY_RIGHT, 1'b1, 1);
      drive(KEY_RIGHT, 1'b0, 2);
      drive(KEY_RIGHT, 1'b1, 3);
      check("t3 held across rise", 256'(menu_out.state), 256'(MENU));
      drive(4'd0, 1'b1, 1);
      drive(KEY_RIGHT, 1'b1, 1);
      check("t3 right after release", 256'(menu_out.state), 256'(SETTINGS));
      drive(4'd0, 1'b1, 1);
      drive(KEY_LEFT, 1'b1, 1);
      check("t3 left", 256'(menu_out.state), 256'(INIT));
      drive(4'd0, 1'b1, 1);

      // 4: DOWN held for 22 cycles after the press
      act_log.delete();
      c0 = seg_changes;
      drive(KEY_DOWN, 1'b1, 23);
      drive(4'd0, 1'b1, 3);
      check("t4 model actions", 256'(act_log.size()), 256'(RPT_EN ? 5 : 1));
      for (int i = 0; i < act_log.size() && i < 5; i++) begin
         check($sformatf("t4 action %0d offset", i), 256'(act_log[i] - act_log[0]), 256'(exp_off[i]));
      end
      check("t4 dut seg changes", 256'(seg_changes - c0), 256'(RPT_EN ? 5 : 1));
      check("t4 seg", 256'(menu_out.seg), 256'("menu  04"));

      // 5: chords/none, then reset mid-hold
      drive(KEY_UP | KEY_DOWN, 1'b1, 3);
      drive(4'd0, 1'b1, 2);
      check("t5 chord", 256'(menu_out.seg), 256'("menu  04"));
      drive(KEY_DOWN, 1'b1, 1);
      rst_n = 1'b0;
      drive(KEY_DOWN, 1'b1, 2);
      rst_n = 1'b1;
      drive(KEY_DOWN, 1'b1, 3);
      check("t5 reset hold seg", 256'(menu_out.seg), 256'("menu  01"));
      check("t5 reset hold state", 256'(menu_out.state), 256'(MENU));
      drive(4'd0, 1'b1, 1);
      drive(KEY_DOWN, 1'b1, 1);
      drive(4'd0, 1'b1, 2);
      check("t5 after release", 256'(menu_out.seg), 256'("menu  02"));

      // Random phase
      for (int s = 0; s < 300; s++) begin
         case ($urandom_range(0, 7))
            0:       rk = 4'd0;
            1:       rk = KEY_UP;
            2:       rk = KEY_DOWN;
            3:       rk = KEY_LEFT;
            4:       rk = KEY_RIGHT;
            5:       rk = KEY_UP | KEY_DOWN;
            6:       rk = 4'($urandom);
            default: rk = KEY_DOWN;
         endcase
         if ($urandom_range(0, 99) < 3) begin
            drive(rk, 1'b1, 2);
            rst_n = 1'b0;
            drive(rk, 1'b1, 2);
            rst_n = 1'b1;
         end
         drive(rk, ($urandom_range(0, 9) != 0), $urandom_range(1, 30));
      end
      drive(4'd0, 1'b1, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
